// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared types and constants for the instruction/unified
// memory arbiter (imem_arbiter) and its grant selector (imem_arb_pick).
//   state_t   - sequencer state encoding (IDLE / ACCESS / DONE)
//   own_t     - grant owner encoding (OWN_IF / OWN_MEM)
//   acc_t     - access payload latched into the memory pins on a grant
//   WORD_MASK - clears the byte-offset bits of a byte address
package imem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } own_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] wdata;
    } acc_t;

    // Word access only: the memory never sees the byte offset.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] adr);
        return adr & WORD_MASK;
    endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// imem_arb_pick: combinational grant selector for the memory arbiter.
// Optional macro IMEM_ARB_FAIR_EN adds a starvation counter that forces an
// IF grant once STARVE_LIM consecutive MEM grants were made while IF waited.
// Without the macro MEM always wins over IF and no counter exists.
// Ports:
//   clk, rst_n  - clock, async active-low reset (counter only)
//   en          - arbiter is idle; a grant reported now is taken
//   if_req      - instruction fetch request
//   mem_req     - load/store request
//   grant_c     - some requester is granted this cycle (combinational)
//   own_c       - owner of that grant (combinational)
module imem_arb_pick
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic if_req,
    input  logic mem_req,
    output logic grant_c,
    output own_t own_c
);

`ifdef IMEM_ARB_FAIR_EN
    localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    logic [SW-1:0] starve;
    logic          if_forced_c;

    // IF has waited through the tolerated number of MEM grants.
    assign if_forced_c = if_req && (starve == LIM);

    // Grant selection with the starvation override.
    always_comb begin
        grant_c = if_req || mem_req;
        own_c   = (mem_req && !if_forced_c) ? OWN_MEM : OWN_IF;
    end

    // Count MEM grants taken while IF was waiting; any IF grant clears it.
    // It never passes LIM: at LIM with IF waiting the grant goes to IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (en && grant_c) begin
            if (own_c == OWN_IF) begin
                starve <= '0;
            end else if (if_req) begin
                starve <= starve + 1'b1;
            end
        end
    end
`else
    logic unused_ok;

    // Clock, reset and enable only feed the starvation counter.
    assign unused_ok = ^{clk, rst_n, en, 32'(STARVE_LIM)};

    // Strict priority: MEM over IF.
    always_comb begin
        grant_c = if_req || mem_req;
        own_c   = mem_req ? OWN_MEM : OWN_IF;
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port word-addressed memory between the
// instruction-fetch port (IF) and the load/store port (MEM). Each access
// takes MEM_LAT cycles in ACCESS followed by one DONE cycle that pulses the
// owner's done flag; read data stays in the owner's rdata register.
// Optional macro IMEM_ARB_FAIR_EN enables starvation protection for IF
// (see imem_arb_pick).
// Parameters:
//   MEM_LAT    - memory access latency in cycles (>= 1)
//   STARVE_LIM - MEM grants tolerated while IF waits (fair build only)
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   if_req/if_adr               - fetch request and byte address
//   if_rdata/if_done            - fetched word, one-cycle completion pulse
//   mem_req/mem_we/mem_adr/
//   mem_wdata                   - data request, store flag, address, data
//   mem_rdata/mem_done          - load data, one-cycle completion pulse
//   ram_adr/ram_load/ram_in     - memory address, write enable, write data
//   ram_out                     - memory read data
//   busy                        - access in progress (ACCESS or DONE)
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_adr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_adr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_done,
    output logic [XLEN-1:0] ram_adr,
    output logic            ram_load,
    output logic [XLEN-1:0] ram_in,
    input  logic [XLEN-1:0] ram_out,
    output logic            busy
);

    localparam int unsigned   CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_t        state;
    own_t          owner;
    logic [CW-1:0] cnt;

    logic          idle_c;
    logic          grant_c;
    own_t          own_c;
    acc_t          sel_c;

    assign idle_c = (state == ST_IDLE);

    // Grant selection (and optional starvation counter).
    imem_arb_pick #(
        .STARVE_LIM (STARVE_LIM)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (idle_c),
        .if_req  (if_req),
        .mem_req (mem_req),
        .grant_c (grant_c),
        .own_c   (own_c)
    );

    // Payload of the requester that would be granted; fetches never write.
    always_comb begin
        sel_c = '{we: 1'b0, adr: if_adr, wdata: '0};
        if (own_c == OWN_MEM) begin
            sel_c = '{we: mem_we, adr: mem_adr, wdata: mem_we ? mem_wdata : '0};
        end
    end

    // Sequencer and memory-side datapath; all outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            cnt       <= '0;
            ram_adr   <= '0;
            ram_load  <= 1'b0;
            ram_in    <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        state    <= ST_ACCESS;
                        owner    <= own_c;
                        cnt      <= CNT_LOAD;
                        busy     <= 1'b1;
                        ram_adr  <= word_align(sel_c.adr);
                        ram_in   <= sel_c.wdata;
                        ram_load <= sel_c.we;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // ram_load still marks a store here; stores keep rdata.
                        if (!ram_load) begin
                            if (owner == OWN_MEM) begin
                                mem_rdata <= ram_out;
                            end else begin
                                if_rdata <= ram_out;
                            end
                        end
                        if (owner == OWN_MEM) begin
                            mem_done <= 1'b1;
                        end else begin
                            if_done <= 1'b1;
                        end
                        ram_load <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Requests seen here are ignored; a held req is served from IDLE.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
